// File: rtl/hazard_forward_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and the forwarding/hazard unit.
// The pipeline side uses master; the control unit uses slave.
interface hazard_forward_ctrl_if #(
  parameter int RA_W = 5
);
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_is_mc;
  logic [RA_W-1:0] ex_rs;
  logic [RA_W-1:0] ex_rt;
  logic [RA_W-1:0] id_ex_wnum;
  logic            id_ex_wen;
  logic            id_ex_is_load;
  logic            mc_issue;
  logic [RA_W-1:0] mc_dst;
  logic [RA_W-1:0] ex_mem_wnum;
  logic [RA_W-1:0] mem_wb_wnum;
  logic            ex_mem_wen;
  logic            mem_wb_wen;
  logic [RA_W-1:0] mem_rt;
  logic            halt_in;

  logic [1:0]      fa;
  logic [1:0]      fb;
  logic            fa_id;
  logic            fb_id;
  logic            f_mem;
  logic            stall_if;
  logic            stall_id;
  logic            flush_ex;
  logic            mc_busy;
  logic            mc_wb_valid;
  logic [RA_W-1:0] mc_wb_num;
  logic            halted;

  modport master (
    output id_rs, id_rt, id_is_mc, ex_rs, ex_rt, id_ex_wnum, id_ex_wen,
           id_ex_is_load, mc_issue, mc_dst, ex_mem_wnum, mem_wb_wnum,
           ex_mem_wen, mem_wb_wen, mem_rt, halt_in,
    input  fa, fb, fa_id, fb_id, f_mem, stall_if, stall_id, flush_ex,
           mc_busy, mc_wb_valid, mc_wb_num, halted
  );

  modport slave (
    input  id_rs, id_rt, id_is_mc, ex_rs, ex_rt, id_ex_wnum, id_ex_wen,
           id_ex_is_load, mc_issue, mc_dst, ex_mem_wnum, mem_wb_wnum,
           ex_mem_wen, mem_wb_wen, mem_rt, halt_in,
    output fa, fb, fa_id, fb_id, f_mem, stall_if, stall_id, flush_ex,
           mc_busy, mc_wb_valid, mc_wb_num, halted
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Forwarding mux selects, load-use / multi-cycle stall generation, a
// single-entry MUL/DIV scoreboard and a halt-drain sequencer.
module hazard_forward_ctrl #(
  parameter int RA_W   = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_forward_ctrl_if.slave bus
);

  localparam int              NREG     = 2 ** RA_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  function automatic logic hit(input logic [RA_W-1:0] src,
                               input logic [RA_W-1:0] prod,
                               input logic            en);
    return en && (src == prod) && (prod != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic [RA_W-1:0] em_n,
                                         input logic            em_en,
                                         input logic [RA_W-1:0] mw_n,
                                         input logic            mw_en,
                                         input logic [RA_W-1:0] mc_n,
                                         input logic            mc_en);
    if (hit(src, em_n, em_en))      return 2'd0;
    else if (hit(src, mw_n, mw_en)) return 2'd1;
    else if (hit(src, mc_n, mc_en)) return 2'd3;
    else                            return 2'd2;
  endfunction

  logic [NREG-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [RA_W-1:0]  dst_q, dst_d;
  state_t           state_q, state_d;
  logic [1:0]       dcnt_q, dcnt_d;

  logic wb_valid;
  logic rs_pend;
  logic rt_pend;
  logic load_use;
  logic mc_haz;
  logic halt_pend;
  logic stall;

  // A destination of r0 still occupies the unit but never writes back.
  assign wb_valid = busy_q && (cnt_q == '0) && (dst_q != '0);

  // The register being written back this cycle is covered by fa/fb = 3.
  assign rs_pend = pending_q[bus.id_rs] && (bus.id_rs != '0) &&
                   !(wb_valid && (dst_q == bus.id_rs));
  assign rt_pend = pending_q[bus.id_rt] && (bus.id_rt != '0) &&
                   !(wb_valid && (dst_q == bus.id_rt));

  assign load_use = bus.id_ex_is_load && bus.id_ex_wen && (bus.id_ex_wnum != '0) &&
                    ((bus.id_ex_wnum == bus.id_rs) || (bus.id_ex_wnum == bus.id_rt));
  assign mc_haz    = rs_pend || rt_pend || (bus.id_is_mc && busy_q);
  assign halt_pend = (state_q != S_RUN);
  assign stall     = load_use || mc_haz || halt_pend;

  assign bus.fa = fwd_sel(bus.ex_rs, bus.ex_mem_wnum, bus.ex_mem_wen,
                          bus.mem_wb_wnum, bus.mem_wb_wen, dst_q, wb_valid);
  assign bus.fb = fwd_sel(bus.ex_rt, bus.ex_mem_wnum, bus.ex_mem_wen,
                          bus.mem_wb_wnum, bus.mem_wb_wen, dst_q, wb_valid);
  assign bus.fa_id = !hit(bus.id_rs, bus.mem_wb_wnum, bus.mem_wb_wen);
  assign bus.fb_id = !hit(bus.id_rt, bus.mem_wb_wnum, bus.mem_wb_wen);
  assign bus.f_mem = hit(bus.mem_rt, bus.mem_wb_wnum, bus.mem_wb_wen);

  assign bus.stall_if    = stall;
  assign bus.stall_id    = stall;
  assign bus.flush_ex    = stall;
  assign bus.mc_busy     = busy_q;
  assign bus.mc_wb_valid = wb_valid;
  assign bus.mc_wb_num   = dst_q;
  assign bus.halted      = (state_q == S_HALT);

  // Scoreboard: one op in flight, issue accepted only while idle.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    dst_d     = dst_q;
    if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        if (dst_q != '0) pending_d[dst_q] = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (bus.mc_issue) begin
      busy_d = 1'b1;
      cnt_d  = CNT_INIT;
      dst_d  = bus.mc_dst;
      if (bus.mc_dst != '0) pending_d[bus.mc_dst] = 1'b1;
    end
  end

  // Halt sequencer: drain needs three empty cycles behind the HALT and an idle MC unit.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_RUN: begin
        if (bus.halt_in && !(load_use || mc_haz)) begin
          state_d = S_DRAIN;
          dcnt_d  = 2'd0;
        end
      end
      S_DRAIN: begin
        if (dcnt_q != 2'd2) dcnt_d = dcnt_q + 2'd1;
        if ((dcnt_q == 2'd2) && !busy_q) state_d = S_HALT;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      dst_q     <= '0;
      state_q   <= S_RUN;
      dcnt_q    <= 2'd0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      dst_q     <= dst_d;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench: the driver pushes per-cycle expectations from a reference
// model; a negedge monitor pops them and compares against the unit's outputs.
module tb_hazard_forward_ctrl;
  localparam int RA_W   = 5;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.RA_W(RA_W)) bus ();

  hazard_forward_ctrl #(.RA_W(RA_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic            rst_n;
    logic [RA_W-1:0] id_rs, id_rt;
    logic            id_is_mc;
    logic [RA_W-1:0] ex_rs, ex_rt, id_ex_wnum;
    logic            id_ex_wen, id_ex_is_load, mc_issue;
    logic [RA_W-1:0] mc_dst, ex_mem_wnum, mem_wb_wnum;
    logic            ex_mem_wen, mem_wb_wen;
    logic [RA_W-1:0] mem_rt;
    logic            halt_in;
  } stim_t;

  typedef struct packed {
    logic [1:0]      fa, fb;
    logic            fa_id, fb_id, f_mem, stall, busy, wbv;
    logic [RA_W-1:0] wbn;
    logic            halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: remaining cycles of the in-flight op, and halt mode 0/1/2 = run/drain/halted.
  int              rem = 0;
  logic [RA_W-1:0] mdst = '0;
  int              mode = 0;
  int              elapsed = 0;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic producer_hit(input logic [RA_W-1:0] src,
                                        input logic [RA_W-1:0] dst, input logic en);
    return en && src == dst && dst != 0;
  endfunction

  // A register blocks ID only while the op has more than its final cycle left.
  function automatic logic still_pending(input logic [RA_W-1:0] r);
    return rem > 1 && r == mdst && r != 0;
  endfunction

  function automatic logic [1:0] ref_sel(input stim_t s, input logic [RA_W-1:0] src,
                                         input logic wbv);
    if (producer_hit(src, s.ex_mem_wnum, s.ex_mem_wen)) return 2'd0;
    if (producer_hit(src, s.mem_wb_wnum, s.mem_wb_wen)) return 2'd1;
    if (producer_hit(src, mdst, wbv))                   return 2'd3;
    return 2'd2;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic lu, mch, busy, wbv;
    rst_n            = s.rst_n;
    bus.id_rs        = s.id_rs;
    bus.id_rt        = s.id_rt;
    bus.id_is_mc     = s.id_is_mc;
    bus.ex_rs        = s.ex_rs;
    bus.ex_rt        = s.ex_rt;
    bus.id_ex_wnum   = s.id_ex_wnum;
    bus.id_ex_wen    = s.id_ex_wen;
    bus.id_ex_is_load = s.id_ex_is_load;
    bus.mc_issue     = s.mc_issue;
    bus.mc_dst       = s.mc_dst;
    bus.ex_mem_wnum  = s.ex_mem_wnum;
    bus.mem_wb_wnum  = s.mem_wb_wnum;
    bus.ex_mem_wen   = s.ex_mem_wen;
    bus.mem_wb_wen   = s.mem_wb_wen;
    bus.mem_rt       = s.mem_rt;
    bus.halt_in      = s.halt_in;

    if (!s.rst_n) begin
      rem = 0; mdst = '0; mode = 0; elapsed = 0;
    end
    busy = rem > 0;
    wbv  = rem == 1 && mdst != 0;
    lu   = s.id_ex_is_load && s.id_ex_wen && s.id_ex_wnum != 0 &&
           (s.id_ex_wnum == s.id_rs || s.id_ex_wnum == s.id_rt);
    mch  = still_pending(s.id_rs) || still_pending(s.id_rt) || (s.id_is_mc && busy);

    e.fa     = ref_sel(s, s.ex_rs, wbv);
    e.fb     = ref_sel(s, s.ex_rt, wbv);
    e.fa_id  = !producer_hit(s.id_rs, s.mem_wb_wnum, s.mem_wb_wen);
    e.fb_id  = !producer_hit(s.id_rt, s.mem_wb_wnum, s.mem_wb_wen);
    e.f_mem  = producer_hit(s.mem_rt, s.mem_wb_wnum, s.mem_wb_wen);
    e.stall  = lu || mch || mode != 0;
    e.busy   = busy;
    e.wbv    = wbv;
    e.wbn    = mdst;
    e.halted = mode == 2;
    exp_q.push_back(e);

    if (s.rst_n) begin
      if (mode == 0 && s.halt_in && !(lu || mch)) begin
        mode = 1; elapsed = 0;
      end else if (mode == 1) begin
        elapsed++;
        if (elapsed >= 3 && !busy) mode = 2;
      end
      if (rem > 0) rem--;
      else if (s.mc_issue) begin
        rem = MC_LAT; mdst = s.mc_dst;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fa", bus.fa, e.fa);
      chk("fb", bus.fb, e.fb);
      chk("fa_id", bus.fa_id, e.fa_id);
      chk("fb_id", bus.fb_id, e.fb_id);
      chk("f_mem", bus.f_mem, e.f_mem);
      chk("stall_if", bus.stall_if, e.stall);
      chk("stall_id", bus.stall_id, e.stall);
      chk("flush_ex", bus.flush_ex, e.stall);
      chk("mc_busy", bus.mc_busy, e.busy);
      chk("mc_wb_valid", bus.mc_wb_valid, e.wbv);
      if (e.wbv) chk("mc_wb_num", bus.mc_wb_num, e.wbn);
      chk("halted", bus.halted, e.halted);
      if (bus.mc_issue) chk("issue_while_busy", bus.mc_busy, 0);
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    @(posedge clk);
    #1;
    step(s);
    step(idle());

    // Forwarding priority and r0 suppression.
    s = idle();
    s.ex_rs = 3; s.id_rs = 3; s.mem_rt = 3;
    s.ex_mem_wnum = 3; s.ex_mem_wen = 1; s.mem_wb_wnum = 3; s.mem_wb_wen = 1;
    step(s);
    s.ex_mem_wen = 0;
    step(s);
    s.ex_mem_wnum = 0; s.mem_wb_wnum = 0; s.ex_mem_wen = 1; s.ex_rs = 0;
    step(s);

    // Load-use then EX/MEM forward.
    s = idle();
    s.id_ex_is_load = 1; s.id_ex_wen = 1; s.id_ex_wnum = 5; s.id_rt = 5;
    step(s);
    s = idle();
    s.ex_rt = 5; s.ex_mem_wnum = 5; s.ex_mem_wen = 1;
    step(s);

    // MC op to r7 with a dependent reader.
    s = idle();
    s.mc_issue = 1; s.mc_dst = 7;
    step(s);
    s = idle();
    s.id_rs = 7; s.ex_rs = 7;
    for (int i = 0; i < 5; i++) step(s);

    // MC op requested while busy, then an r0-destination op.
    s = idle();
    s.mc_issue = 1; s.mc_dst = 9;
    step(s);
    s = idle();
    s.id_is_mc = 1;
    for (int i = 0; i < 5; i++) step(s);
    s = idle();
    s.mc_issue = 1; s.mc_dst = 0;
    step(s);
    s = idle();
    for (int i = 0; i < 5; i++) step(s);

    // Halt with an MC op in flight, then reset out of HALT.
    s = idle();
    s.mc_issue = 1; s.mc_dst = 4;
    step(s);
    step(idle());
    s = idle();
    s.halt_in = 1;
    step(s);
    for (int i = 0; i < 8; i++) step(idle());
    s = idle();
    s.rst_n = 0;
    step(s);
    step(idle());

    // Reset in the middle of an MC op.
    s = idle();
    s.mc_issue = 1; s.mc_dst = 6;
    step(s);
    step(idle());
    s = idle();
    s.rst_n = 0;
    step(s);
    s = idle();
    s.id_rs = 6; s.ex_rs = 6;
    for (int i = 0; i < 6; i++) step(s);

    // Randomized traffic on a narrow register range so matches are frequent.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.id_rs         = RA_W'($urandom_range(0, 7));
      s.id_rt         = RA_W'($urandom_range(0, 7));
      s.id_is_mc      = ($urandom_range(0, 7) == 0);
      s.ex_rs         = RA_W'($urandom_range(0, 7));
      s.ex_rt         = RA_W'($urandom_range(0, 7));
      s.id_ex_wnum    = RA_W'($urandom_range(0, 7));
      s.id_ex_wen     = $urandom_range(0, 1) == 1;
      s.id_ex_is_load = $urandom_range(0, 2) == 0;
      s.mc_dst        = RA_W'($urandom_range(0, 7));
      s.mc_issue      = (rem == 0) && (mode == 0) && ($urandom_range(0, 3) == 0);
      s.ex_mem_wnum   = RA_W'($urandom_range(0, 7));
      s.mem_wb_wnum   = RA_W'($urandom_range(0, 7));
      s.ex_mem_wen    = $urandom_range(0, 1) == 1;
      s.mem_wb_wen    = $urandom_range(0, 1) == 1;
      s.mem_rt        = RA_W'($urandom_range(0, 7));
      s.halt_in       = ($urandom_range(0, 63) == 0);
      s.rst_n         = ($urandom_range(0, 59) != 0);
      step(s);
    end

    step(idle());
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
